prog_mem_arbiter: RTL and testbench

PROG_MEM_ARBITER -- requirements
Module: prog_mem_arbiter

---
 rtl/prog_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_prog_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_arbiter.sv
// Program-memory port arbiter: shares one read port between instruction fetch
// and the 3-cycle LPM (load program memory) byte-load sequence.
module prog_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_stall,
    input  logic              lpm_start,
    input  logic [1:0]        lpm_mode,
    input  logic [4:0]        lpm_rd,
    input  logic [15:0]       z_in,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              pmem_rd,
    input  logic [DATA_W-1:0] pmem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [7:0]        rf_wdata,
    output logic              z_we,
    output logic [15:0]       z_out,
    output logic              lpm_busy,
    output logic              lpm_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LPM_ADDR = 2'd1,
        LPM_DATA = 2'd2,
        LPM_WB   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_z;
    logic [4:0]  r_rd;
    logic [1:0]  r_mode;
    logic [7:0]  r_byte;
    logic        r_fetch_pend;

    logic        w_idle;
    logic        w_lpm_accept;
    logic        w_fetch_accept;
    logic [7:0]  w_sel_byte;

    assign w_idle         = (r_state == IDLE);
    // LPM wins a same-cycle collision; the fetch is refused via fetch_stall.
    assign w_lpm_accept   = !reset && w_idle && lpm_start;
    assign w_fetch_accept = !reset && w_idle && fetch_req && !lpm_start;
    assign w_sel_byte     = r_z[0] ? pmem_rdata[15:8] : pmem_rdata[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_z          <= 16'd0;
            r_rd         <= 5'd0;
            r_mode       <= 2'd0;
            r_byte       <= 8'd0;
            r_fetch_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pend <= w_fetch_accept;
            if (w_lpm_accept) begin
                r_z    <= z_in;
                r_rd   <= lpm_rd;
                r_mode <= lpm_mode;
            end
            if (r_state == LPM_DATA) begin
                r_byte <= w_sel_byte;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        fetch_valid  = 1'b0;
        fetch_data   = '0;
        fetch_stall  = 1'b0;
        pmem_addr    = '0;
        pmem_rd      = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_wdata     = 8'd0;
        z_we         = 1'b0;
        z_out        = 16'd0;
        lpm_busy     = 1'b0;
        lpm_done     = 1'b0;

        // While reset is asserted every output is held low, including a
        // fetch response that would otherwise appear this cycle.
        if (!reset) begin
            fetch_valid = r_fetch_pend;
            fetch_data  = r_fetch_pend ? pmem_rdata : '0;
            fetch_stall = lpm_start || !w_idle;
            lpm_busy    = !w_idle;

            case (r_state)
                IDLE: begin
                    if (lpm_start) begin
                        w_state_next = LPM_ADDR;
                    end else if (fetch_req) begin
                        pmem_rd   = 1'b1;
                        pmem_addr = fetch_addr;
                    end
                end
                LPM_ADDR: begin
                    pmem_rd      = 1'b1;
                    pmem_addr    = r_z[ADDR_W:1];
                    w_state_next = LPM_DATA;
                end
                LPM_DATA: begin
                    w_state_next = LPM_WB;
                end
                LPM_WB: begin
                    rf_we        = 1'b1;
                    rf_wdata     = r_byte;
                    rf_waddr     = (r_mode == 2'b00) ? 5'd0 : r_rd;
                    lpm_done     = 1'b1;
                    // Reserved mode 11 falls through as plain LPM Rd,Z.
                    if (r_mode == 2'b10) begin
                        z_we  = 1'b1;
                        z_out = r_z + 16'd1;
                    end
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Scoreboard bench for prog_mem_arbiter: directed fetch/LPM vectors push
// expected responses; a negedge monitor pops and compares them.
module tb_prog_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_stall;
    logic              lpm_start;
    logic [1:0]        lpm_mode;
    logic [4:0]        lpm_rd;
    logic [15:0]       z_in;
    logic [ADDR_W-1:0] pmem_addr;
    logic              pmem_rd;
    logic [DATA_W-1:0] pmem_rdata = '0;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [7:0]        rf_wdata;
    logic              z_we;
    logic [15:0]       z_out;
    logic              lpm_busy;
    logic              lpm_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          at;
        logic [15:0] data;
    } fetch_exp_t;

    typedef struct {
        int          at;
        logic [4:0]  waddr;
        logic [7:0]  wdata;
        logic        zwe;
        logic [15:0] zout;
    } lpm_exp_t;

    fetch_exp_t fetch_q[$];
    lpm_exp_t   lpm_q[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    prog_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_stall(fetch_stall),
        .lpm_start  (lpm_start),
        .lpm_mode   (lpm_mode),
        .lpm_rd     (lpm_rd),
        .z_in       (z_in),
        .pmem_addr  (pmem_addr),
        .pmem_rd    (pmem_rd),
        .pmem_rdata (pmem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .z_we       (z_we),
        .z_out      (z_out),
        .lpm_busy   (lpm_busy),
        .lpm_done   (lpm_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pmem_rd) pmem_rdata <= mem[pmem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", nm, act, cyc);
        end
    endtask

    // Monitor: checks every DUT response against the scoreboard queues.
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (fetch_q.size() == 0) begin
                chk("unexpected_fetch_valid", 32'(fetch_valid), 32'd0);
            end else begin
                fetch_exp_t fe;
                fe = fetch_q.pop_front();
                chk("fetch_cycle", 32'(cyc), 32'(fe.at));
                chk("fetch_data", 32'(fetch_data), 32'(fe.data));
            end
        end
        if (rf_we || lpm_done || z_we) begin
            if (lpm_q.size() == 0) begin
                chk("unexpected_lpm_write", {29'd0, rf_we, lpm_done, z_we}, 32'd0);
            end else begin
                lpm_exp_t le;
                le = lpm_q.pop_front();
                chk("lpm_cycle", 32'(cyc), 32'(le.at));
                chk("lpm_rf_we_done", {30'd0, rf_we, lpm_done}, 32'd3);
                chk("lpm_waddr", 32'(rf_waddr), 32'(le.waddr));
                chk("lpm_wdata", 32'(rf_wdata), 32'(le.wdata));
                chk("lpm_z_we", 32'(z_we), 32'(le.zwe));
                chk("lpm_z_out", 32'(z_out), 32'(le.zout));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lpm(input int at, input logic [4:0] wa, input logic [7:0] wd,
                            input logic zwe, input logic [15:0] zo);
        lpm_exp_t le;
        le.at = at; le.waddr = wa; le.wdata = wd; le.zwe = zwe; le.zout = zo;
        lpm_q.push_back(le);
    endtask

    task automatic push_fetch(input int at, input logic [15:0] d);
        fetch_exp_t fe;
        fe.at = at; fe.data = d;
        fetch_q.push_back(fe);
    endtask

    task automatic start_lpm(input logic [1:0] mode, input logic [4:0] rd, input logic [15:0] z);
        lpm_start = 1'b1;
        lpm_mode  = mode;
        lpm_rd    = rd;
        z_in      = z;
    endtask

    task automatic chk_all_zero(input string nm);
        #1;
        chk(nm, {fetch_valid, fetch_stall, pmem_rd, rf_we, z_we, lpm_busy, lpm_done,
                 4'(0), rf_waddr, rf_wdata}, 32'd0);
        chk({nm, "_wide"}, {fetch_data, z_out}, 32'd0);
        chk({nm, "_addr"}, 32'(pmem_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i * 7 + 3);
        mem[14'h0000] = 16'h1234;
        mem[14'h0010] = 16'h940C;
        mem[14'h0020] = 16'hBEEF;
        mem[14'h0080] = 16'hABCD;
        mem[14'h3FFF] = 16'h5A77;

        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        lpm_start = 1'b0; lpm_mode = 2'd0; lpm_rd = 5'd0; z_in = 16'd0;
        step(); step();
        chk_all_zero("reset_outputs");
        reset = 1'b0;
        chk_all_zero("post_reset_outputs");

        // Plain fetch
        fetch_req = 1'b1; fetch_addr = 14'h0010;
        #1;
        chk("fetch_pmem_rd", 32'(pmem_rd), 32'd1);
        chk("fetch_pmem_addr", 32'(pmem_addr), 32'h0010);
        chk("fetch_no_stall", 32'(fetch_stall), 32'd0);
        push_fetch(cyc + 1, 16'h940C);
        step(); fetch_req = 1'b0;

        // LPM Rd,Z+ with odd Z: high byte, Z incremented
        step();
        start_lpm(2'b10, 5'd16, 16'h0101);
        push_lpm(cyc + 3, 5'd16, 8'hAB, 1'b1, 16'h0102);
        step(); lpm_start = 1'b0;
        #1;
        chk("lpm_addr_rd", 32'(pmem_rd), 32'd1);
        chk("lpm_addr_addr", 32'(pmem_addr), 32'h0080);
        chk("lpm_busy", 32'(lpm_busy), 32'd1);
        step();
        #1 chk("lpm_data_no_rd", 32'(pmem_rd), 32'd0);
        step(); step();

        // Collision: LPM R0,Z wins, fetch stalls 4 cycles then is accepted
        fetch_req = 1'b1; fetch_addr = 14'h0020;
        start_lpm(2'b00, 5'd7, 16'h0000);
        push_lpm(cyc + 3, 5'd0, 8'h34, 1'b0, 16'h0000);
        #1 chk("collide_fetch_refused", 32'(pmem_addr), 32'h0000);
        for (int i = 0; i < 4; i++) begin
            #1 chk("collide_stall", 32'(fetch_stall), 32'd1);
            step();
            lpm_start = 1'b0;
        end
        #1;
        chk("collide_stall_released", 32'(fetch_stall), 32'd0);
        chk("collide_fetch_addr", 32'(pmem_addr), 32'h0020);
        push_fetch(cyc + 1, 16'hBEEF);
        step(); fetch_req = 1'b0;

        // Z wrap: 0xFFFF -> 0x0000, word address 0x3FFF
        step();
        start_lpm(2'b10, 5'd3, 16'hFFFF);
        push_lpm(cyc + 3, 5'd3, 8'h5A, 1'b1, 16'h0000);
        step(); lpm_start = 1'b0;
        #1 chk("wrap_pmem_addr", 32'(pmem_addr), 32'h3FFF);
        step(); step(); step();

        // Fetch in N, LPM in N+1: fetch still delivered, LPM_ADDR in N+2
        fetch_req = 1'b1; fetch_addr = 14'h0010;
        push_fetch(cyc + 1, 16'h940C);
        step();
        fetch_req = 1'b0;
        start_lpm(2'b01, 5'd5, 16'h0020);
        push_lpm(cyc + 3, 5'd5, 8'h0C, 1'b0, 16'h0000);
        step(); lpm_start = 1'b0;
        #1 chk("back2back_lpm_addr", 32'(pmem_addr), 32'h0010);
        step(); step(); step();

        // Reserved mode 11 acts as LPM Rd,Z
        start_lpm(2'b11, 5'd9, 16'h0040);
        push_lpm(cyc + 3, 5'd9, 8'hEF, 1'b0, 16'h0000);
        step(); lpm_start = 1'b0;
        step(); step(); step();

        // Second lpm_start while busy is ignored
        start_lpm(2'b01, 5'd2, 16'h0001);
        push_lpm(cyc + 3, 5'd2, 8'h12, 1'b0, 16'h0000);
        step();
        start_lpm(2'b10, 5'd20, 16'h0101);
        #1 chk("ignore_latched_addr", 32'(pmem_addr), 32'h0000);
        step(); lpm_start = 1'b0;
        step(); step(); step();

        // Reset during LPM_DATA aborts the write-back
        start_lpm(2'b10, 5'd16, 16'h0101);
        step(); lpm_start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("reset_mid_lpm");
        start_lpm(2'b00, 5'd11, 16'h0001);
        push_lpm(cyc + 3, 5'd0, 8'h12, 1'b0, 16'h0000);
        step(); lpm_start = 1'b0;
        step(); step(); step();

        // Reset drops a pending fetch response
        fetch_req = 1'b1; fetch_addr = 14'h0010;
        step();
        fetch_req = 1'b0; reset = 1'b1;
        #1 chk("reset_drops_fetch", 32'(fetch_valid), 32'd0);
        step();
        reset = 1'b0;

        repeat (5) step();
        chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
        chk("lpm_queue_drained", 32'(lpm_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
